wait_state_memory: RTL and testbench

- Behavioural and synthesizable word memory that sits directly downstream of the mp0 CPU memory port. It replaces the zero-wait magic memory in benches that need realistic stalls.
- Accepts the CPU's read/write/byte-enable request, holds it for a programmable number of wait states, then returns a single-cycle resp.
- Flags requester protocol violations so the CPU's memory FSM can be checked under latency.

---
 rtl/wait_state_memory.sv | 206 ++++++++++++++++++++
 tb/tb_wait_state_memory.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_memory.sv
// ----------------------------------------------------------------------------
// wait_state_memory
//
// Word memory placed behind the mp0 CPU memory port. It accepts one request,
// holds it for a fixed number of wait states and then answers with a
// single-cycle resp. It also records requester protocol violations in a
// sticky flag.
//
// Parameters:
//   LATENCY  cycles from request acceptance to resp (1..15)
//   WORDS    number of 16-bit words; word index = address[15:1] mod WORDS
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   read_i       read strobe, held until resp
//   write_i      write strobe, held until resp
//   wmask_i      write byte enables (bit0 -> [7:0], bit1 -> [15:8])
//   address_i    byte address, bit 0 ignored
//   wdata_i      write data
//   resp_o       one-cycle completion pulse
//   rdata_o      read data, valid with resp on a read, held afterwards
//   busy_o       high from acceptance through the resp cycle
//   proto_err_o  sticky protocol-violation flag, cleared only by reset
//
// Optional feature (macro WAIT_STATE_JITTER_EN): an 8-bit Fibonacci LFSR
// (taps 8,6,5,4, reset 8'hA5) advances once per accepted request and its
// bits [1:0] are added to the wait count, giving LATENCY..LATENCY+3.
// ----------------------------------------------------------------------------
module wait_state_memory #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned WORDS   = 32768
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [1:0]  wmask_i,
    input  logic [15:0] address_i,
    input  logic [15:0] wdata_i,
    output logic        resp_o,
    output logic [15:0] rdata_o,
    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_write_q, op_write_d;
    logic [14:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  wmask_q, wmask_d;
    logic [15:0] rdata_q, rdata_d;
    logic        perr_q, perr_d;

    logic [15:0] mem_q [WORDS];

    logic            accept;
    logic            clash;
    logic            commit;
    logic            mem_we;
    logic            violation;
    logic [1:0]      jitter;
    logic [IdxW-1:0] idx;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = address_i[0];

    assign accept = (state_q == StIdle) && (read_i ^ write_i);
    assign clash  = (state_q == StIdle) && read_i && write_i;
    assign commit = (state_q == StWait) && (cnt_q == 5'd0);
    assign mem_we = commit && op_write_q;

    // Aliasing is done on the latched word address at commit time.
    assign idx = IdxW'(32'(waddr_q) % WORDS);

`ifdef WAIT_STATE_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Value before the advance is the one that applies to this request.
    assign jitter = lfsr_q[1:0];
`else
    assign jitter = 2'b00;
`endif

    // Requester must hold strobe, address and (for writes) data/mask steady
    // from acceptance until the edge that ends the resp cycle.
    always_comb begin
        violation = 1'b0;
        if (state_q == StWait || state_q == StResp) begin
            if (address_i[15:1] != waddr_q) begin
                violation = 1'b1;
            end
            if (op_write_q) begin
                if (!write_i || read_i || wdata_i != wdata_q || wmask_i != wmask_q) begin
                    violation = 1'b1;
                end
            end else begin
                if (!read_i || write_i) begin
                    violation = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        perr_d     = perr_q | violation | clash;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_write_d = write_i;
                    waddr_d    = address_i[15:1];
                    wdata_d    = wdata_i;
                    wmask_d    = wmask_i;
                    cnt_d      = 5'(LATENCY - 1) + {3'b000, jitter};
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 5'd0) begin
                    state_d = StResp;
                    if (!op_write_q) begin
                        rdata_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            op_write_q <= 1'b0;
            waddr_q    <= 15'd0;
            wdata_q    <= 16'h0000;
            wmask_q    <= 2'b00;
            rdata_q    <= 16'h0000;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            perr_q     <= perr_d;
        end
    end

    // Array is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we) begin
            if (wmask_q[0]) begin
                mem_q[idx][7:0] <= wdata_q[7:0];
            end
            if (wmask_q[1]) begin
                mem_q[idx][15:8] <= wdata_q[15:8];
            end
        end
    end

    assign resp_o      = (state_q == StResp);
    assign busy_o      = (state_q != StIdle);
    assign rdata_o     = rdata_q;
    assign proto_err_o = perr_q;

endmodule

// File: tb/tb_wait_state_memory.sv
module tb_wait_state_memory;

    localparam int unsigned LAT   = 3;
    localparam int unsigned WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [1:0]  wmask;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        resp;
    logic [15:0] rdata;
    logic        busy;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    // Reference model: sparse word array, last returned read data, jitter LFSR.
    logic [15:0] mem_m [int];
    logic [15:0] rdata_m;
    logic [7:0]  lfsr_m;

    wait_state_memory #(
        .LATENCY (LAT),
        .WORDS   (WORDS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .read_i      (rd),
        .write_i     (wr),
        .wmask_i     (wmask),
        .address_i   (address),
        .wdata_i     (wdata),
        .resp_o      (resp),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .proto_err_o (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [15:0] a);
        return (int'(a) / 2) % int'(WORDS);
    endfunction

    // Latency the model expects for the next accepted request.
    task automatic next_lat(output int lat);
`ifdef WAIT_STATE_JITTER_EN
        lat    = int'(LAT) + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
        lat = int'(LAT);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rdata_m = 16'h0000;
        lfsr_m  = 8'hA5;
    endtask

    // perturb: 0 none, 1 addr bit1 flip, 2 drop strobe, 3 wdata change,
    // 4 opposite strobe, 5 addr bit0 flip (legal)
    task automatic txn(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [1:0] wm, input bit use_exp, input logic [15:0] exp_rd,
                       input int perturb, input string tag);
        int  lat;
        int  i;
        int  idx;
        bit  seen;
        bit  busy_ok;
        logic [15:0] old;
        next_lat(lat);
        idx = idx_of(addr);
        if (is_wr) begin
            old = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
            mem_m[idx] = {wm[1] ? wd[15:8] : old[15:8], wm[0] ? wd[7:0] : old[7:0]};
        end else begin
            rdata_m = mem_m[idx];
        end
        rd      = !is_wr;
        wr      = is_wr;
        address = addr;
        wdata   = wd;
        wmask   = wm;
        seen    = 1'b0;
        busy_ok = 1'b1;
        i       = 0;
        while (!seen && i < lat + 10) begin
            @(posedge clk);
            #1;
            i++;
            if (!busy) busy_ok = 1'b0;
            if (resp) begin
                seen = 1'b1;
            end else if (i == 1) begin
                case (perturb)
                    1: address = address ^ 16'h0002;
                    2: begin rd = 1'b0; wr = 1'b0; end
                    3: wdata = wdata ^ 16'h0101;
                    4: if (is_wr) rd = 1'b1; else wr = 1'b1;
                    5: address = address ^ 16'h0001;
                    default: ;
                endcase
            end
        end
        check({tag, " resp latency"}, seen ? i : -1, lat + 1);
        check({tag, " busy during txn"}, int'(busy_ok), 1);
        check({tag, " rdata"}, int'(rdata), int'(use_exp ? exp_rd : rdata_m));
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        check({tag, " idle after resp"}, int'({resp, busy}), 0);
    endtask

    initial begin
        int  w;
        bit  is_wr;
        bit  flag;
        logic [1:0]  wm;
        logic [15:0] a;
        logic [15:0] d;

        tbl[0]  = '{1'b1, 16'h0010, 16'h1234, 2'b11, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'h1234};
        tbl[2]  = '{1'b1, 16'h0020, 16'h0000, 2'b11, 16'h1234};
        tbl[3]  = '{1'b1, 16'h0020, 16'hBEEF, 2'b01, 16'h1234};
        tbl[4]  = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'h00EF};
        tbl[5]  = '{1'b1, 16'h0020, 16'hCA00, 2'b10, 16'h00EF};
        tbl[6]  = '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'hCAEF};
        tbl[7]  = '{1'b1, 16'h0021, 16'h5555, 2'b00, 16'hCAEF};
        tbl[8]  = '{1'b0, 16'h0021, 16'h0000, 2'b00, 16'hCAEF};
        tbl[9]  = '{1'b1, 16'h0040, 16'hABCD, 2'b11, 16'hCAEF};
        tbl[10] = '{1'b0, 16'h0840, 16'h0000, 2'b00, 16'hABCD};
        tbl[11] = '{1'b1, 16'hF842, 16'h1111, 2'b11, 16'hABCD};
        tbl[12] = '{1'b0, 16'h0042, 16'h0000, 2'b00, 16'h1111};

        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        wmask   = 2'b00;
        address = 16'h0000;
        wdata   = 16'h0000;
        do_reset();

        check("reset resp", int'(resp), 0);
        check("reset busy", int'(busy), 0);
        check("reset rdata", int'(rdata), 0);
        check("reset proto_err", int'(proto_err), 0);

        for (int k = 0; k < 13; k++) begin
            txn(tbl[k].is_wr, tbl[k].addr, tbl[k].wd, tbl[k].wm, 1'b1, tbl[k].exp_rd, 0,
                $sformatf("vec%0d", k));
        end
        check("no proto_err after clean vectors", int'(proto_err), 0);

        // Memory survives reset.
        do_reset();
        check("rdata after reset", int'(rdata), 0);
        txn(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 16'h1234, 0, "read after reset");

        // Both strobes in IDLE: rejected, flagged, memory untouched.
        rd = 1'b1; wr = 1'b1; address = 16'h0010; wdata = 16'hFFFF; wmask = 2'b11;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        check("clash busy", int'(busy), 0);
        check("clash resp", int'(resp), 0);
        check("clash proto_err", int'(proto_err), 1);
        @(posedge clk);
        #1;
        check("clash stays idle", int'({resp, busy}), 0);
        txn(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 16'h1234, 0, "read after clash");
        check("proto_err sticky", int'(proto_err), 1);
        do_reset();
        check("proto_err cleared by reset", int'(proto_err), 0);

        // Mid-transaction violations; transaction still completes with latched values.
        txn(1'b0, 16'h0040, 16'h0000, 2'b00, 1'b1, 16'hABCD, 1, "addr change");
        check("addr change proto_err", int'(proto_err), 1);
        do_reset();
        txn(1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 16'h0000, 2, "strobe drop");
        check("strobe drop proto_err", int'(proto_err), 1);
        do_reset();
        txn(1'b1, 16'h0060, 16'h4242, 2'b11, 1'b0, 16'h0000, 3, "wdata change");
        check("wdata change proto_err", int'(proto_err), 1);
        do_reset();
        txn(1'b0, 16'h0060, 16'h0000, 2'b00, 1'b0, 16'h0000, 0, "latched wdata");
        txn(1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 16'h0000, 4, "opposite strobe");
        check("opposite strobe proto_err", int'(proto_err), 1);
        do_reset();
        txn(1'b0, 16'h0042, 16'h0000, 2'b00, 1'b0, 16'h0000, 5, "addr bit0 change");
        check("addr bit0 no proto_err", int'(proto_err), 0);
        do_reset();

        // Reset during WAIT abandons the write.
        rd = 1'b0; wr = 1'b1; address = 16'h0020; wdata = 16'h7777; wmask = 2'b11;
        @(posedge clk);
        #1;
        check("abandoned write busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr = 1'b0;
        rdata_m = 16'h0000;
        lfsr_m = 8'hA5;
        check("mid-wait reset outputs", int'({resp, busy, proto_err}), 0);
        check("mid-wait reset rdata", int'(rdata), 0);
        flag = 1'b0;
        repeat (LAT + 6) begin
            @(posedge clk);
            #1;
            if (resp || busy) flag = 1'b1;
        end
        check("no resp after mid-wait reset", int'(flag), 0);
        txn(1'b0, 16'h0020, 16'h0000, 2'b00, 1'b1, 16'hCAEF, 0, "old value kept");

        // Randomized traffic with aliasing high address bits.
        for (int n = 0; n < 60; n++) begin
            w     = int'($urandom_range(0, 15));
            a     = 16'(($urandom_range(0, 31) << 11) | (w << 1) | $urandom_range(0, 1));
            is_wr = 1'($urandom_range(0, 1));
            wm    = 2'($urandom_range(0, 3));
            d     = 16'($urandom);
            if (!mem_m.exists(idx_of(a))) begin
                is_wr = 1'b1;
                wm    = 2'b11;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            txn(is_wr, a, d, wm, 1'b0, 16'h0000, 0, $sformatf("rnd%0d", n));
        end
        check("no proto_err after random traffic", int'(proto_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
